// File: rtl/golden_nonce_arbiter.sv
// golden_nonce_arbiter
// Captures per-core golden-nonce strobes into holding registers, picks one
// pending core per cycle round-robin, and queues the nonce in a small
// first-word-fall-through FIFO with a valid/ready output.
// Optional feature macro: GN_DROP_COUNT_EN builds the saturating counter of
// results lost to a still-pending holding register; without it drop_count
// reads zero.
module golden_nonce_arbiter #(
    parameter int NCORES     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          hash_clk,
    input  logic                          rst_n,
    input  logic [NCORES-1:0]             gn_match,
    input  logic [32*NCORES-1:0]          gn_nonce,
    input  logic                          flush,
    output logic                          out_valid,
    output logic [31:0]                   out_nonce,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic [15:0]                   drop_count
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int RRW = (NCORES > 1) ? $clog2(NCORES) : 1;

    // Per-core holding registers and pending flags
    logic [31:0]       hold_q [NCORES];
    logic [NCORES-1:0] pend_q;
    logic [NCORES-1:0] pend_d;
    logic [NCORES-1:0] capture;

    // Round-robin pointer and grant
    logic [RRW-1:0]    rr_q;
    logic [RRW-1:0]    rr_d;
    logic              grant_vld;
    logic [RRW-1:0]    grant_idx;
    logic [RRW-1:0]    scan_idx;
    logic [NCORES-1:0] grant_oh;

    // Result FIFO
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     rd_ptr_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              full_w;
    logic              push;
    logic              pop;

    assign full_w     = (count_q == CW'(FIFO_DEPTH));
    assign fifo_full  = full_w;
    assign fifo_count = count_q;
    assign out_valid  = (count_q != '0);
    // Gate the head with valid so an empty FIFO (including right after reset)
    // never exposes an old entry.
    assign out_nonce  = out_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;

    // Find the first pending core starting at rr; no grant while the FIFO is full
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NCORES; k++) begin
            scan_idx = RRW'((int'(rr_q) + k) % NCORES);
            if (!grant_vld && pend_q[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (full_w) begin
            grant_vld = 1'b0;
        end
    end

    // Per-core grant decode, capture enable and next pending state.
    // A granted core may take a new nonce in the same cycle because its
    // current one is leaving for the FIFO; otherwise a busy slot drops it.
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
        assign grant_oh[gi] = grant_vld && (grant_idx == RRW'(gi));
        assign capture[gi]  = gn_match[gi] & (~pend_q[gi] | grant_oh[gi]) & ~flush;
        assign pend_d[gi]   = flush ? 1'b0
                                    : (capture[gi] | (pend_q[gi] & ~grant_oh[gi]));
    end

    assign push = grant_vld & ~flush;
    assign pop  = out_valid & out_ready & ~flush;
    assign rr_d = flush     ? '0
                : grant_vld ? RRW'((int'(grant_idx) + 1) % NCORES)
                :             rr_q;

    // FIFO pointer and occupancy next-state; flush empties the queue
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Holding registers take the core nonce whenever a capture is accepted
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCORES; i++) begin
                hold_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if (capture[i]) begin
                    hold_q[i] <= gn_nonce[32*i +: 32];
                end
            end
        end
    end

    // Control state: pending flags, rr pointer, FIFO pointers and count
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only visible through out_nonce when valid
    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= hold_q[grant_idx];
        end
    end

`ifdef GN_DROP_COUNT_EN
    logic [NCORES-1:0] drop_vec;
    logic [15:0]       drop_cnt_q;
    logic [15:0]       drop_cnt_d;
    logic [16:0]       drop_sum;

    // A drop is a match on a busy slot that is not being granted; flushed
    // matches are discarded rather than counted.
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_drop
        assign drop_vec[gi] = gn_match[gi] & pend_q[gi] & ~grant_oh[gi] & ~flush;
    end

    // Add every core dropping this cycle, saturating at all-ones
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NCORES; i++) begin
            drop_sum = drop_sum + 17'(drop_vec[i]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Drop counter register, cleared only by reset
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Directed testbench for golden_nonce_arbiter (NCORES=4, FIFO_DEPTH=8).
module tb_golden_nonce_arbiter;

    localparam int NC = 4;
    localparam int FD = 8;
`ifdef GN_DROP_COUNT_EN
    localparam logic [15:0] DROP_EXP = 16'h0001;
`else
    localparam logic [15:0] DROP_EXP = 16'h0000;
`endif

    logic              hash_clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     gn_match;
    logic [32*NC-1:0]  gn_nonce;
    logic              flush;
    logic              out_valid;
    logic [31:0]       out_nonce;
    logic              out_ready;
    logic [3:0]        fifo_count;
    logic              fifo_full;
    logic [15:0]       drop_count;

    int n_vec = 0;
    int n_err = 0;

    golden_nonce_arbiter #(.NCORES(NC), .FIFO_DEPTH(FD)) dut (
        .hash_clk   (hash_clk),
        .rst_n      (rst_n),
        .gn_match   (gn_match),
        .gn_nonce   (gn_nonce),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_nonce  (out_nonce),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic set_nonce(input int core, input logic [31:0] v);
        gn_nonce[32*core +: 32] = v;
    endtask

    logic [31:0] exp_n [4];

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        gn_match  = '0;
        gn_nonce  = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_full",  32'(fifo_full), 32'h0);
        chk("rst_nonce", out_nonce, 32'h0);
        chk("rst_drop",  32'(drop_count), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single result: 2-cycle latency, then drained
        out_ready = 1'b1;
        set_nonce(0, 32'h0000_1234);
        gn_match = 4'b0001;
        tick();
        gn_match = '0;
        chk("t1_valid_e0", 32'(out_valid), 32'h0);
        tick();
        chk("t1_valid_e1", 32'(out_valid), 32'h1);
        chk("t1_nonce",    out_nonce, 32'h0000_1234);
        chk("t1_count1",   32'(fifo_count), 32'h1);
        tick();
        chk("t1_valid_e2", 32'(out_valid), 32'h0);
        chk("t1_count0",   32'(fifo_count), 32'h0);

        // Simultaneous matches from all cores, rr starts at 0 after flush
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_n[0] = 32'h0800_0001;
        exp_n[1] = 32'h1000_0002;
        exp_n[2] = 32'h1800_0003;
        exp_n[3] = 32'h2000_0004;
        for (int i = 0; i < 4; i++) set_nonce(i, exp_n[i]);
        gn_match = 4'b1111;
        tick();
        gn_match = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t2_valid%0d", i), 32'(out_valid), 32'h1);
            chk($sformatf("t2_nonce%0d", i), out_nonce, exp_n[i]);
        end
        chk("t2_rr", 32'(dut.rr_q), 32'h0);
        tick();
        chk("t2_empty", 32'(out_valid), 32'h0);

        // Fairness: grant core 1 to move rr to 2, then pend cores 0 and 2
        set_nonce(1, 32'h0000_0111);
        gn_match = 4'b0010;
        tick();
        gn_match = '0;
        tick();
        chk("t3_pre_nonce", out_nonce, 32'h0000_0111);
        set_nonce(0, 32'hC0C0_0000);
        set_nonce(2, 32'hC2C2_0002);
        gn_match = 4'b0101;
        tick();
        gn_match = '0;
        chk("t3_rr",    32'(dut.rr_q), 32'h2);
        chk("t3_pend",  32'(dut.pend_q), 32'h5);
        chk("t3_valid", 32'(out_valid), 32'h0);
        tick();
        chk("t3_first",  out_nonce, 32'hC2C2_0002);
        tick();
        chk("t3_second", out_nonce, 32'hC0C0_0000);
        tick();
        chk("t3_empty", 32'(out_valid), 32'h0);

        // Full FIFO and drop on core 1
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            set_nonce(1, 32'hA000_0000 + 32'(i));
            gn_match = 4'b0010;
            tick();
            gn_match = '0;
            repeat (18) tick();
        end
        chk("t4_full",  32'(fifo_full), 32'h1);
        chk("t4_count", 32'(fifo_count), 32'h8);
        chk("t4_pend1", 32'(dut.pend_q[1]), 32'h1);
        chk("t4_hold1", dut.hold_q[1], 32'hA000_0009);
        set_nonce(1, 32'hA000_000A);
        gn_match = 4'b0010;
        tick();
        gn_match = '0;
        tick();
        chk("t4_drop",       32'(drop_count), 32'(DROP_EXP));
        chk("t4_hold1_keep", dut.hold_q[1], 32'hA000_0009);
        chk("t4_count_keep", 32'(fifo_count), 32'h8);
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            chk($sformatf("t4_drain_v%0d", i), 32'(out_valid), 32'h1);
            chk($sformatf("t4_drain_n%0d", i), out_nonce, 32'hA000_0000 + 32'(i));
            tick();
        end
        chk("t4_drained", 32'(out_valid), 32'h0);
        chk("t4_count0",  32'(fifo_count), 32'h0);

        // Flush priority over a same-cycle match
        out_ready = 1'b0;
        set_nonce(1, 32'hB000_0001);
        set_nonce(2, 32'hB000_0002);
        set_nonce(3, 32'hB000_0003);
        gn_match = 4'b1110;
        tick();
        gn_match = '0;
        repeat (3) tick();
        set_nonce(0, 32'hB000_0000);
        gn_match = 4'b0001;
        tick();
        gn_match = '0;
        chk("t5_pre_count", 32'(fifo_count), 32'h3);
        chk("t5_pre_pend",  32'(dut.pend_q), 32'h1);
        flush = 1'b1;
        set_nonce(2, 32'hDEAD_0002);
        gn_match = 4'b0100;
        tick();
        flush = 1'b0;
        gn_match = '0;
        chk("t5_valid", 32'(out_valid), 32'h0);
        chk("t5_count", 32'(fifo_count), 32'h0);
        chk("t5_pend",  32'(dut.pend_q), 32'h0);
        chk("t5_rr",    32'(dut.rr_q), 32'h0);
        chk("t5_drop",  32'(drop_count), 32'(DROP_EXP));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_quiet%0d", i), 32'(out_valid), 32'h0);
        end

        // Asynchronous reset with five entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_nonce(i, 32'hE000_0000 + 32'(i));
        gn_match = 4'b1111;
        tick();
        gn_match = '0;
        repeat (4) tick();
        set_nonce(0, 32'hE000_0010);
        gn_match = 4'b0001;
        tick();
        gn_match = '0;
        tick();
        chk("t6_count5", 32'(fifo_count), 32'h5);
        out_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_count", 32'(fifo_count), 32'h0);
        chk("t6_nonce", out_nonce, 32'h0);
        chk("t6_full",  32'(fifo_full), 32'h0);
        chk("t6_drop",  32'(drop_count), 32'h0);
        chk("t6_pend",  32'(dut.pend_q), 32'h0);
        #20;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_after%0d", i), 32'(out_valid), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/golden_nonce_arbiter.md
# golden_nonce_arbiter

Collects golden-nonce results from NCORES parallel hashcore instances and queues them for the serial reporting path. Each core's one-cycle `golden_nonce_match` strobe and `golden_nonce_out` value are captured into a per-core holding register, and a round-robin arbiter grants one holding register per cycle into a small FIFO. The FIFO presents results to the UART transmit logic over a valid/ready handshake. The block sits between the hashcore array and the serial comms module, so simultaneous matches from different cores are never lost.

## Interface

Parameters:
- NCORES, 4: number of hashcore instances (1..32; matches the 5-bit `nonce_msb` core prefix).
- FIFO_DEPTH, 8: result FIFO entries (power of two, ≥ 2).

Ports:
- hash_clk  in  1  clock for all logic.
- rst_n  in  1  reset, asynchronous assert, active-low.
- gn_match  in  NCORES  per-core golden-nonce strobe; bit i is high for one cycle per match.
- gn_nonce  in  32*NCORES  core i nonce on [32i+31:32i]; valid only while gn_match[i] is high.
- flush  in  1  synchronous clear of all pending and queued results (pulsed when new work finishes shifting in).
- out_valid  out  1  FIFO head holds a result.
- out_nonce  out  32  FIFO head nonce.
- out_ready  in  1  consumer accepts the head this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- fifo_full  out  1  fifo_count == FIFO_DEPTH.
- drop_count  out  16  number of lost results (see Configuration).

## Operation

- **Capture.** On gn_match[i], hold[i] <= gn_nonce[i] and pend[i] <= 1.
  - If pend[i] is already 1 and core i is not granted that cycle, the new result is dropped. hold[i] keeps the older nonce.
  - If core i is granted in the same cycle, the new nonce is captured and pend[i] stays 1.
- **Arbitration.**
  - Combinational round-robin over pend[]. The search starts at pointer rr and proceeds rr, rr+1, … mod NCORES.
  - At most one grant per cycle.
  - A grant happens only when fifo_full == 0. A same-cycle pop does not free a slot for that cycle's grant.
  - On grant of core g: pend[g] cleared (unless re-set by a same-cycle match), hold[g] written to the FIFO tail, rr <= (g+1) mod NCORES.
  - With no grant, rr is unchanged.
- **FIFO.**
  - First-word-fall-through: out_valid = (fifo_count != 0) and out_nonce = head entry.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - out_ready while empty is ignored.
- **Flush.**
  - Next cycle: pend[] = 0, FIFO empty, rr = 0.
  - Flush takes priority over same-cycle gn_match (those matches are discarded and not counted as drops) and over same-cycle grant and pop.
  - drop_count is not affected by flush.
- **Reset (rst_n low, asynchronous).** out_valid 0, out_nonce 0, fifo_count 0, fifo_full 0, drop_count 0, rr 0, pend[] 0, hold[] 0.
- **Hold value.** out_nonce is stable while out_valid = 1 and out_ready = 0.

## Timing

- Match sampled at edge E0 → pend set after E0 → grant and FIFO write at E1 → out_valid high after E1. Latency is 2 cycles when the FIFO is not full and there is no contention.
- Throughput: one result per cycle into and out of the FIFO.
- Worst-case wait from pend set to grant: NCORES-1 cycles (FIFO not full).
- Hashcore strobes recur at most once per 19 cycles per core. A drop therefore requires backpressure on out_ready for more than 19 cycles.
- No combinational path from gn_match or gn_nonce to any output. out_ready affects only registered state.

## Configuration

- **GN_DROP_COUNT_EN defined:**
  - drop_count increments by 1 per dropped result (per core, per cycle), saturating at 16'hFFFF.
  - If several cores drop in the same cycle, drop_count increments by the number of dropping cores, still saturating.
  - Cleared only by reset.
- **GN_DROP_COUNT_EN undefined:**
  - drop_count is tied to 16'h0000 and no counter logic is built.
  - Drop behaviour on the data path is unchanged.

## Test plan

- **Single result.** Reset, then gn_match = 4'b0001 with core 0 nonce 32'h0000_1234, out_ready = 1 → out_valid high exactly 2 cycles after the strobe with out_nonce 32'h0000_1234, then low the next cycle; fifo_count returns to 0.
- **Simultaneous matches.** gn_match = 4'b1111 in one cycle, nonces 32'h0800_0001, 32'h1000_0002, 32'h1800_0003, 32'h2000_0004, out_ready = 1 → four consecutive out_valid cycles in order core 0, 1, 2, 3; rr = 0 afterwards.
- **Fairness.** With rr = 2 and pend = 4'b0101 → core 2 is granted first, then core 0.
- **Full FIFO and drop.**
  - FIFO_DEPTH = 8, out_ready = 0.
  - Core 1 strobes nine times, spaced 19 cycles apart, with nonces N1..N9.
  - Required: fifo_full = 1, fifo_count = 8, pend[1] = 1 holding N9.
  - A tenth strobe with N10 → drop_count = 1 (with GN_DROP_COUNT_EN), hold[1] still N9.
  - Raising out_ready drains N1..N9 in order.
- **Flush priority.** With 3 entries queued and pend[0] = 1, assert flush in the same cycle as gn_match[2] → next cycle out_valid = 0, fifo_count = 0, pend = 0, drop_count unchanged; no result from core 2 ever appears.
- **Reset mid-operation.** With 5 entries queued and out_ready = 1, assert rst_n low between clock edges → all outputs return to their reset values immediately, without waiting for a clock edge; no stale nonce appears after rst_n deasserts.
